// File: rtl/wb_arb_2.sv
// Two-master to one-slave Wishbone arbiter. Grant held for whole CYC,
// round-robin or fixed priority; watchdog when WB_ARB_TIMEOUT_EN defined.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wbm0_* / wbm1_*   master-side Wishbone ports (adr/dat/we/sel/stb/cyc in,
//                     dat/ack/err/rty out)
//   wbs_*             slave-side Wishbone port
//
// Optional feature macro: WB_ARB_TIMEOUT_EN (transfer watchdog of TIMEOUT).
module wb_arb_2 #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int SELECT_WIDTH    = 4,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int TIMEOUT         = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
  input  logic                    wbm0_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
  input  logic                    wbm0_stb_i,
  output logic                    wbm0_ack_o,
  output logic                    wbm0_err_o,
  output logic                    wbm0_rty_o,
  input  logic                    wbm0_cyc_i,
  input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
  input  logic                    wbm1_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
  input  logic                    wbm1_stb_i,
  output logic                    wbm1_ack_o,
  output logic                    wbm1_err_o,
  output logic                    wbm1_rty_o,
  input  logic                    wbm1_cyc_i,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    wbs_cyc_o
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("wb_arb_2: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } grant_e;

  grant_e grant_q, grant_d;
  logic   last_q, last_d;
  logic   hold;
  logic   g0, g1;
  logic   cyc_raw, stb_raw;
  logic   to_hit;

  assign g0 = (grant_q == G0);
  assign g1 = (grant_q == G1);

  assign hold = (g0 & wbm0_cyc_i) | (g1 & wbm1_cyc_i);

  // Grant selection; a released grant hands over on the same edge.
  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (!hold) begin
      if (wbm0_cyc_i & wbm1_cyc_i) begin
        if ((ARB_ROUND_ROBIN != 0) && !last_q) grant_d = G1;
        else                                   grant_d = G0;
      end else if (wbm0_cyc_i) begin
        grant_d = G0;
      end else if (wbm1_cyc_i) begin
        grant_d = G1;
      end else begin
        grant_d = IDLE;
      end
    end
    if (grant_d != grant_q) begin
      if (grant_d == G0) last_d = 1'b0;
      if (grant_d == G1) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Slave-side request mux.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    cyc_raw   = 1'b0;
    stb_raw   = 1'b0;
    unique case (grant_q)
      G0: begin
        wbs_adr_o = wbm0_adr_i;
        wbs_dat_o = wbm0_dat_i;
        wbs_sel_o = wbm0_sel_i;
        wbs_we_o  = wbm0_we_i;
        cyc_raw   = wbm0_cyc_i;
        stb_raw   = wbm0_stb_i;
      end
      G1: begin
        wbs_adr_o = wbm1_adr_i;
        wbs_dat_o = wbm1_dat_i;
        wbs_sel_o = wbm1_sel_i;
        wbs_we_o  = wbm1_we_i;
        cyc_raw   = wbm1_cyc_i;
        stb_raw   = wbm1_stb_i;
      end
      default: ;
    endcase
  end

  assign wbs_cyc_o = cyc_raw;
  assign wbs_stb_o = stb_raw & ~to_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          term;

  assign term = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // A real slave termination in the limit cycle takes precedence.
  assign to_hit = cyc_raw & stb_raw & ~term &
                  (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (grant_d != grant_q) begin
      cnt_d = '0;
    end else if (term | to_hit) begin
      cnt_d = '0;
    end else if (cyc_raw & stb_raw) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Responses go only to the granted master; read data is broadcast.
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign wbm0_ack_o = g0 & wbs_ack_i;
  assign wbm1_ack_o = g1 & wbs_ack_i;
  assign wbm0_err_o = g0 & (wbs_err_i | to_hit);
  assign wbm1_err_o = g1 & (wbs_err_i | to_hit);
  assign wbm0_rty_o = g0 & wbs_rty_i;
  assign wbm1_rty_o = g1 & wbs_rty_i;

endmodule

// File: tb/tb_wb_arb_2.sv
// Bench for wb_arb_2: round-robin and fixed-priority instances share stimulus,
// each checked every cycle against a grant/timeout model plus literal checks.
module tb_wb_arb_2;

  localparam int TMO = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk, rst_n;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic [31:0] s_dat_i;
  logic        s_ack, s_err, s_rty;

  logic [31:0] o_mdat [2][2];
  logic        o_mack [2][2];
  logic        o_merr [2][2];
  logic        o_mrty [2][2];
  logic [31:0] o_sadr [2];
  logic [31:0] o_sdat [2];
  logic [3:0]  o_ssel [2];
  logic        o_swe  [2];
  logic        o_sstb [2];
  logic        o_scyc [2];

  int n_cmp = 0;
  int n_bad = 0;

  // d=0: round-robin, d=1: fixed priority
  for (genvar d = 0; d < 2; d++) begin : g_dut
    wb_arb_2 #(
      .ARB_ROUND_ROBIN(d == 0 ? 1 : 0),
      .TIMEOUT(TMO)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .wbm0_adr_i(m_adr[0]), .wbm0_dat_i(m_dat[0]),
      .wbm0_dat_o(o_mdat[d][0]), .wbm0_we_i(m_we[0]),
      .wbm0_sel_i(m_sel[0]), .wbm0_stb_i(m_stb[0]),
      .wbm0_ack_o(o_mack[d][0]), .wbm0_err_o(o_merr[d][0]),
      .wbm0_rty_o(o_mrty[d][0]), .wbm0_cyc_i(m_cyc[0]),
      .wbm1_adr_i(m_adr[1]), .wbm1_dat_i(m_dat[1]),
      .wbm1_dat_o(o_mdat[d][1]), .wbm1_we_i(m_we[1]),
      .wbm1_sel_i(m_sel[1]), .wbm1_stb_i(m_stb[1]),
      .wbm1_ack_o(o_mack[d][1]), .wbm1_err_o(o_merr[d][1]),
      .wbm1_rty_o(o_mrty[d][1]), .wbm1_cyc_i(m_cyc[1]),
      .wbs_adr_o(o_sadr[d]), .wbs_dat_i(s_dat_i),
      .wbs_dat_o(o_sdat[d]), .wbs_we_o(o_swe[d]),
      .wbs_sel_o(o_ssel[d]), .wbs_stb_o(o_sstb[d]),
      .wbs_ack_i(s_ack), .wbs_err_i(s_err),
      .wbs_rty_i(s_rty), .wbs_cyc_o(o_scyc[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: owner index (-1 = none), last granted, watchdog count.
  int own [2];
  int lst [2];
  int cnt [2];

  function automatic bit term();
    return s_ack | s_err | s_rty;
  endfunction

  function automatic bit tohit(int d);
    int o;
    o = own[d];
    if (!TO_EN || o < 0) return 1'b0;
    return m_cyc[o] && m_stb[o] && !term() && (cnt[d] == TMO - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        own[d] = -1;
        lst[d] = 1;
        cnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int  nxt;
        bit  th;
        th  = tohit(d);
        nxt = own[d];
        if (!(own[d] >= 0 && m_cyc[own[d]])) begin
          if (m_cyc[0] && m_cyc[1]) nxt = (d == 0) ? 1 - lst[d] : 0;
          else if (m_cyc[0])        nxt = 0;
          else if (m_cyc[1])        nxt = 1;
          else                      nxt = -1;
        end
        if (nxt != own[d]) begin
          cnt[d] = 0;
          if (nxt >= 0) lst[d] = nxt;
        end else if (term() || th) begin
          cnt[d] = 0;
        end else if (own[d] >= 0 && m_cyc[own[d]] && m_stb[own[d]]) begin
          cnt[d] = cnt[d] + 1;
        end
        own[d] = nxt;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int o, oi;
      bit has, th;
      o   = own[d];
      has = (o >= 0);
      oi  = has ? o : 0;
      th  = tohit(d);
      chk($sformatf("m%0d_cyc", d), o_scyc[d], has ? m_cyc[oi] : 1'b0);
      chk($sformatf("m%0d_stb", d), o_sstb[d],
          has ? (m_stb[oi] & !th) : 1'b0);
      chk($sformatf("m%0d_we", d),  o_swe[d],  has ? m_we[oi]  : 1'b0);
      chk($sformatf("m%0d_adr", d), o_sadr[d], has ? m_adr[oi] : 32'h0);
      chk($sformatf("m%0d_dat", d), o_sdat[d], has ? m_dat[oi] : 32'h0);
      chk($sformatf("m%0d_sel", d), o_ssel[d], has ? m_sel[oi] : 4'h0);
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("m%0d_ack%0d", d, n), o_mack[d][n], s_ack && o == n);
        chk($sformatf("m%0d_err%0d", d, n), o_merr[d][n],
            (s_err || th) && o == n);
        chk($sformatf("m%0d_rty%0d", d, n), o_mrty[d][n], s_rty && o == n);
        chk($sformatf("m%0d_rdat%0d", d, n), o_mdat[d][n], s_dat_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_dat_i = 32'h0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rty   = 1'b0;
    for (int n = 0; n < 2; n++) begin
      m_adr[n] = '0; m_dat[n] = '0; m_sel[n] = '0;
      m_we[n] = 1'b0; m_stb[n] = 1'b0; m_cyc[n] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_cyc", o_scyc[0], 1'b0);
    chk("rst_ack", o_mack[0][0], 1'b0);

    // Contention from reset grants master 0 in both modes.
    step();
    m_adr[0] = 32'hA0; m_dat[0] = 32'h1111; m_sel[0] = 4'h3; m_we[0] = 1'b1;
    m_adr[1] = 32'hB0; m_dat[1] = 32'h2222; m_sel[1] = 4'hC;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1 chk("idle_cyc", o_scyc[0], 1'b0);
    step();
    s_ack = 1'b1; s_dat_i = 32'h5A5A;
    #1;
    chk("c_rr_adr", o_sadr[0], 32'hA0);
    chk("c_fx_adr", o_sadr[1], 32'hA0);
    chk("c_ack0", o_mack[0][0], 1'b1);
    chk("c_ack1", o_mack[0][1], 1'b0);
    chk("c_rdat1", o_mdat[0][1], 32'h5A5A);
    step();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1 chk("rel_cyc", o_scyc[0], 1'b0);
    step();
    #1;
    chk("hand_rr", o_sadr[0], 32'hB0);
    chk("hand_fx", o_sadr[1], 32'hB0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    #1 chk("back_rr", o_sadr[0], 32'hA0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1 chk("idle2_cyc", o_scyc[1], 1'b0);
    step();
    #1;
    chk("rr_pick1", o_sadr[0], 32'hB0);
    chk("fx_pick0", o_sadr[1], 32'hA0);

    // Hold across stb gaps with the other master requesting.
    for (int k = 0; k < 3; k++) begin
      m_stb[0] = 1'b1; s_ack = 1'b1;
      #1;
      chk("hold_fx_ack", o_mack[1][0], 1'b1);
      chk("hold_rr_ack", o_mack[0][1], 1'b1);
      step();
      m_stb[0] = 1'b0; s_ack = 1'b0;
      #1;
      chk("hold_fx_adr", o_sadr[1], 32'hA0);
      chk("hold_fx_stb", o_sstb[1], 1'b0);
      step();
    end
    m_cyc[0] = 1'b0;
    #1 chk("drop_fx_adr", o_sadr[1], 32'hA0);
    step();
    #1 chk("after_fx_adr", o_sadr[1], 32'hB0);
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();

    // Watchdog: stalled slave.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("to_err_%0d", k), o_merr[0][0], (k == 3) ? TO_EN : 1'b0);
      chk($sformatf("to_stb_%0d", k), o_sstb[0], (k == 3) ? !TO_EN : 1'b1);
      step();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();

    // Async reset mid-transfer.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    step();
    s_ack = 1'b1;
    #1 chk("pre_rst_ack", o_mack[0][0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cyc_rr", o_scyc[0], 1'b0);
    chk("arst_cyc_fx", o_scyc[1], 1'b0);
    chk("arst_ack", o_mack[0][0], 1'b0);
    s_ack = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1 chk("post_rst_cyc", o_scyc[0], 1'b0);
    step();
    #1 chk("post_rst_adr", o_sadr[0], 32'hA0);
    s_err = 1'b1;
    #1;
    chk("err0", o_merr[0][0], 1'b1);
    chk("err1", o_merr[0][1], 1'b0);
    step();
    s_err = 1'b0; s_rty = 1'b1;
    #1 chk("rty0", o_mrty[1][0], 1'b1);
    step();
    s_rty = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();

    // Single master 1 at address 0x100.
    m_adr[1] = 32'h100; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    #1 chk("s_idle", o_scyc[0], 1'b0);
    step();
    s_ack = 1'b1;
    #1;
    chk("s_cyc", o_scyc[0], 1'b1);
    chk("s_adr", o_sadr[0], 32'h100);
    chk("s_ack1", o_mack[0][1], 1'b1);
    chk("s_ack0", o_mack[0][0], 1'b0);
    step();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
